// File: rtl/rx_iq_arbiter.sv
// RX1/RX2 IQ sample arbiter onto a shared FIFO write port, with pair ordering and overrun detection.
// Optional saturating lost-sample counter: define RX_IQ_OVR_CNT_EN to build it; otherwise ovr_cnt reads 0.
module rx_iq_arbiter #(
    parameter int IQ_WIDTH = 24
) (
    input  logic                  clk_in,
    input  logic                  reset_n,
    input  logic                  rx1_en,
    input  logic                  rx2_en,
    input  logic                  rx1_valid,
    input  logic [IQ_WIDTH-1:0]   rx1_i,
    input  logic [IQ_WIDTH-1:0]   rx1_q,
    input  logic                  rx2_valid,
    input  logic [IQ_WIDTH-1:0]   rx2_i,
    input  logic [IQ_WIDTH-1:0]   rx2_q,
    input  logic                  flush,
    input  logic                  ovr_clr,
    input  logic                  fifo_full,
    output logic                  fifo_wr,
    output logic [2*IQ_WIDTH:0]   fifo_data,
    output logic                  overrun,
    output logic [7:0]            ovr_cnt,
    output logic [1:0]            dbg_state
);

    // Handshake: rxN_valid is a one-cycle strobe with no ready; fifo_wr may only
    // fire when fifo_full was low in the cycle before the write edge.
    typedef enum logic [1:0] {SINGLE = 2'd0, EXP1 = 2'd1, EXP2 = 2'd2} state_t;

    state_t              state, state_nxt;
    logic                full1, full2;
    logic [IQ_WIDTH-1:0] hold1_i, hold1_q, hold2_i, hold2_q;
    logic                pair, drain1, drain2, cap1, cap2, ov1, ov2;

    assign pair      = rx1_en & rx2_en;
    assign cap1      = rx1_valid & rx1_en & ~flush;
    assign cap2      = rx2_valid & rx2_en & ~flush;
    assign ov1       = cap1 & full1 & ~drain1;
    assign ov2       = cap2 & full2 & ~drain2;
    assign dbg_state = state;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) state <= SINGLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = pair ? EXP1 : SINGLE;
        end else if (!pair) begin
            state_nxt = SINGLE;
        end else begin
            case (state)
                SINGLE:  state_nxt = EXP1;
                EXP1:    if (drain1) state_nxt = EXP2;
                EXP2:    if (drain2) state_nxt = EXP1;
                default: state_nxt = SINGLE;
            endcase
        end
    end

    // Grant: SINGLE only serves a lone enabled channel so a fresh pair always starts with RX1.
    always_comb begin
        drain1 = 1'b0;
        drain2 = 1'b0;
        if (!fifo_full && !flush) begin
            case (state)
                SINGLE: begin
                    drain1 = full1 & rx1_en & ~rx2_en;
                    drain2 = full2 & rx2_en & ~rx1_en;
                end
                EXP1:    drain1 = full1 & pair;
                EXP2:    drain2 = full2 & pair;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            full1   <= 1'b0;
            full2   <= 1'b0;
            hold1_i <= '0;
            hold1_q <= '0;
            hold2_i <= '0;
            hold2_q <= '0;
        end else begin
            if (flush || !rx1_en) full1 <= 1'b0;
            else if (cap1)        full1 <= 1'b1;
            else if (drain1)      full1 <= 1'b0;
            if (flush || !rx2_en) full2 <= 1'b0;
            else if (cap2)        full2 <= 1'b1;
            else if (drain2)      full2 <= 1'b0;
            if (cap1) begin
                hold1_i <= rx1_i;
                hold1_q <= rx1_q;
            end
            if (cap2) begin
                hold2_i <= rx2_i;
                hold2_q <= rx2_q;
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            fifo_wr   <= 1'b0;
            fifo_data <= '0;
        end else begin
            fifo_wr <= drain1 | drain2;
            if (drain1)      fifo_data <= {1'b0, hold1_q, hold1_i};
            else if (drain2) fifo_data <= {1'b1, hold2_q, hold2_i};
        end
    end

    // A fresh overrun wins over a same-edge clear.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n)        overrun <= 1'b0;
        else if (ov1 || ov2) overrun <= 1'b1;
        else if (ovr_clr)    overrun <= 1'b0;
    end

`ifdef RX_IQ_OVR_CNT_EN
    logic [7:0] cnt_q;
    logic [1:0] ovr_inc;
    logic [8:0] ovr_sum;

    always_comb begin
        ovr_inc = {1'b0, ov1} + {1'b0, ov2};
        ovr_sum = (ovr_clr ? 9'd0 : {1'b0, cnt_q}) + {7'd0, ovr_inc};
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) cnt_q <= 8'd0;
        else          cnt_q <= ovr_sum[8] ? 8'd255 : ovr_sum[7:0];
    end

    assign ovr_cnt = cnt_q;
`else
    assign ovr_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_rx_iq_arbiter.sv
// Directed bench for rx_iq_arbiter: latency, pair ordering, back-pressure/overrun, flush, async reset.
module tb_rx_iq_arbiter;

    localparam int W  = 24;
    localparam int DW = 2*W + 1;
`ifdef RX_IQ_OVR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk_in = 1'b0;
    logic          reset_n = 1'b0;
    logic          rx1_en = 1'b0, rx2_en = 1'b0;
    logic          rx1_valid = 1'b0, rx2_valid = 1'b0;
    logic [W-1:0]  rx1_i = '0, rx1_q = '0, rx2_i = '0, rx2_q = '0;
    logic          flush = 1'b0, ovr_clr = 1'b0, fifo_full = 1'b0;
    logic          fifo_wr;
    logic [DW-1:0] fifo_data;
    logic          overrun;
    logic [7:0]    ovr_cnt;
    logic [1:0]    dbg_state;

    logic [DW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_errors = 0;

    rx_iq_arbiter #(.IQ_WIDTH(W)) dut (
        .clk_in(clk_in), .reset_n(reset_n),
        .rx1_en(rx1_en), .rx2_en(rx2_en),
        .rx1_valid(rx1_valid), .rx1_i(rx1_i), .rx1_q(rx1_q),
        .rx2_valid(rx2_valid), .rx2_i(rx2_i), .rx2_q(rx2_q),
        .flush(flush), .ovr_clr(ovr_clr), .fifo_full(fifo_full),
        .fifo_wr(fifo_wr), .fifo_data(fifo_data),
        .overrun(overrun), .ovr_cnt(ovr_cnt), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    function automatic logic [DW-1:0] word(input logic ch, input logic [W-1:0] i, input logic [W-1:0] q);
        return {ch, q, i};
    endfunction

    task automatic strobe1(input logic [W-1:0] i, input logic [W-1:0] q);
        rx1_i = i; rx1_q = q; rx1_valid = 1'b1;
        step();
        rx1_valid = 1'b0;
    endtask

    task automatic strobe2(input logic [W-1:0] i, input logic [W-1:0] q);
        rx2_i = i; rx2_q = q; rx2_valid = 1'b1;
        step();
        rx2_valid = 1'b0;
    endtask

    // scoreboard: every FIFO write must match the head of exp_q
    always @(negedge clk_in) begin
        if (reset_n && fifo_wr) begin
            if (exp_q.size() == 0) chk("unexpected_wr", 64'(fifo_data), 64'h1_0000_0000_0000_0);
            else                   chk("wr_data", 64'(fifo_data), 64'(exp_q.pop_front()));
        end
    end

    initial begin
        logic [DW-1:0] w;
        logic [W-1:0]  a, b;

        // reset state
        #12;
        chk("rst_fifo_wr", 64'(fifo_wr), 64'd0);
        chk("rst_fifo_data", 64'(fifo_data), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        chk("rst_ovr_cnt", 64'(ovr_cnt), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'd0);
        @(negedge clk_in);
        reset_n = 1'b1;
        step();

        // RX1 only: latency and data format
        rx1_en = 1'b1;
        step();
        w = word(1'b0, 24'h000123, 24'hFFFFFE);
        exp_q.push_back(w);
        rx1_i = 24'h000123; rx1_q = 24'hFFFFFE; rx1_valid = 1'b1;
        step();
        rx1_valid = 1'b0;
        chk("lat_c1_no_wr", 64'(fifo_wr), 64'd0);
        step();
        chk("lat_c2_wr", 64'(fifo_wr), 64'd1);
        chk("lat_c2_data", 64'(fifo_data), 64'(w));
        chk("rx1_overrun", 64'(overrun), 64'd0);
        step();
        chk("wr_pulse_end", 64'(fifo_wr), 64'd0);
        chk("data_hold", 64'(fifo_data), 64'(w));

        // pair ordering: RX2 arrives 5 cycles ahead of RX1
        rx2_en = 1'b1;
        step();
        chk("pair_state_exp1", 64'(dbg_state), 64'd1);
        for (int p = 0; p < 100; p++) begin
            a = W'(p * 3 + 1);
            b = W'(24'h800000 | p);
            exp_q.push_back(word(1'b0, a, ~a));
            exp_q.push_back(word(1'b1, b, ~b));
            strobe2(b, ~b);
            step(4);
            strobe1(a, ~a);
            step(4);
        end
        chk("pair_q_empty", 64'(exp_q.size()), 64'd0);
        chk("pair_overrun", 64'(overrun), 64'd0);

        // mid-pair disable
        strobe1(24'h111111, 24'h222222);
        exp_q.push_back(word(1'b0, 24'h111111, 24'h222222));
        step(2);
        chk("mid_exp2", 64'(dbg_state), 64'd2);
        rx2_en = 1'b0;
        step();
        chk("mid_single", 64'(dbg_state), 64'd0);
        exp_q.push_back(word(1'b0, 24'h333333, 24'h444444));
        strobe1(24'h333333, 24'h444444);
        step(3);
        chk("mid_unpaired_q", 64'(exp_q.size()), 64'd0);
        rx2_en = 1'b1;
        step();
        exp_q.push_back(word(1'b0, 24'h555555, 24'h666666));
        exp_q.push_back(word(1'b1, 24'h777777, 24'h888888));
        strobe2(24'h777777, 24'h888888);
        strobe1(24'h555555, 24'h666666);
        step(4);
        chk("mid_reenable_q", 64'(exp_q.size()), 64'd0);
        rx2_en = 1'b0;
        step();

        // same-edge drain and capture, RX1 only
        for (int s = 0; s < 1000; s++) begin
            a = W'(s * 7 + 5);
            exp_q.push_back(word(1'b0, a, ~a));
            strobe1(a, ~a);
            step();
        end
        for (int s = 0; s < 200; s++) begin
            a = W'(s + 24'h400000);
            exp_q.push_back(word(1'b0, a, a));
            rx1_i = a; rx1_q = a; rx1_valid = 1'b1;
            step();
        end
        rx1_valid = 1'b0;
        step(3);
        chk("stream_overrun", 64'(overrun), 64'd0);
        chk("stream_q_empty", 64'(exp_q.size()), 64'd0);

        // back-pressure: three strobes, newest wins
        fifo_full = 1'b1;
        strobe1(24'h0000AA, 24'h0000AB);
        strobe1(24'h0000BA, 24'h0000BB);
        strobe1(24'h0000CA, 24'h0000CB);
        chk("bp_overrun", 64'(overrun), 64'd1);
        chk("bp_ovr_cnt", 64'(ovr_cnt), CNT_EN ? 64'd2 : 64'd0);
        exp_q.push_back(word(1'b0, 24'h0000CA, 24'h0000CB));
        fifo_full = 1'b0;
        step(3);
        chk("bp_single_wr", 64'(exp_q.size()), 64'd0);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        chk("clr_overrun", 64'(overrun), 64'd0);
        chk("clr_ovr_cnt", 64'(ovr_cnt), 64'd0);

        // ovr_clr on the same edge as a new overrun, then flush
        fifo_full = 1'b1;
        strobe1(24'h0000D1, 24'h0000D2);
        ovr_clr = 1'b1;
        strobe1(24'h0000E1, 24'h0000E2);
        ovr_clr = 1'b0;
        chk("clr_ovr_same_flag", 64'(overrun), 64'd1);
        chk("clr_ovr_same_cnt", 64'(ovr_cnt), CNT_EN ? 64'd1 : 64'd0);
        flush = 1'b1;
        rx1_valid = 1'b1;
        step();
        flush = 1'b0;
        rx1_valid = 1'b0;
        chk("flush_keeps_ovr", 64'(overrun), 64'd1);
        chk("flush_keeps_cnt", 64'(ovr_cnt), CNT_EN ? 64'd1 : 64'd0);
        fifo_full = 1'b0;
        step(3);
        chk("flush_no_wr", 64'(exp_q.size()), 64'd0);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;

        // saturation: 301 strobes under back-pressure = 300 overruns
        fifo_full = 1'b1;
        rx1_valid = 1'b1;
        step(301);
        rx1_valid = 1'b0;
        step();
        chk("sat_ovr_cnt", 64'(ovr_cnt), CNT_EN ? 64'd255 : 64'd0);
        chk("sat_overrun", 64'(overrun), 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        fifo_full = 1'b0;
        step(2);

        // async reset mid-cycle with a held sample and overrun pending
        fifo_full = 1'b1;
        strobe1(24'h0000F1, 24'h0000F2);
        strobe1(24'h0000F3, 24'h0000F4);
        @(posedge clk_in);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_fifo_wr", 64'(fifo_wr), 64'd0);
        chk("arst_overrun", 64'(overrun), 64'd0);
        chk("arst_ovr_cnt", 64'(ovr_cnt), 64'd0);
        chk("arst_state", 64'(dbg_state), 64'd0);
        step();
        fifo_full = 1'b0;
        @(negedge clk_in);
        reset_n = 1'b1;
        step(4);
        chk("arst_no_wr", 64'(fifo_wr), 64'd0);
        chk("final_q_empty", 64'(exp_q.size()), 64'd0);

        // final report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
